mul_shift_add_ctrl: RTL and testbench

Sequential unsigned shift-add multiplier. It is the multiply counterpart of the restoring-divide control/datapath in the ALU Part3 block. It owns its own product register, adder and iteration counter, and runs a 2-cycle-per-bit FSM (add, then shift). A run/ready handshake lets the ALU top start an operation and pick up a full double-width product.

---
 rtl/alu_pkg.sv | 21 ++
 rtl/mul_datapath.sv | 63 ++++++
 rtl/mul_shift_add_ctrl.sv | 101 ++++++++++
 tb/tb_mul_shift_add_ctrl.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Purpose: constants shared by the ALU multiply control and datapath.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package alu_pkg;

  // Default operand width; the product is twice this.
  localparam int unsigned MUL_WIDTH = 32;

  // FSM state encoding.
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ADD   = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  // Iteration counter width. The extra bit keeps the counter from wrapping
  // on the last increment.
  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/mul_datapath.sv
// Purpose: product/multiplicand/carry registers and the (W+1)-bit adder of the
//          shift-add multiplier, sequenced by load/add/shift strobes.
// Latency: one edge per strobe. Backpressure: none; strobes are obeyed unconditionally.
// Ports: clk, rst (async active-low), load_i/add_en_i/shift_en_i strobes,
//        mcand_i/mplier_i operands, product_o (2*WIDTH result register).
module mul_datapath #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_i,
  input  logic               add_en_i,
  input  logic               shift_en_i,
  input  logic [WIDTH-1:0]   mcand_i,
  input  logic [WIDTH-1:0]   mplier_i,
  output logic [2*WIDTH-1:0] product_o
);

  logic [WIDTH-1:0]   mcand_q,   mcand_d;
  logic [2*WIDTH-1:0] product_q, product_d;
  logic               carry_q,   carry_d;
  logic [WIDTH:0]     sum;

  // Adder output keeps the carry-out so the upper half never overflows.
  assign sum = {1'b0, product_q[2*WIDTH-1:WIDTH]} + {1'b0, mcand_q};

  always_comb begin
    mcand_d   = mcand_q;
    product_d = product_q;
    carry_d   = carry_q;
    if (load_i) begin
      // Multiplier sits in the lower half and is consumed LSB first.
      mcand_d   = mcand_i;
      product_d = {{WIDTH{1'b0}}, mplier_i};
      carry_d   = 1'b0;
    end else if (add_en_i) begin
      if (product_q[0]) begin
        {carry_d, product_d[2*WIDTH-1:WIDTH]} = sum;
      end else begin
        carry_d = 1'b0;
      end
    end else if (shift_en_i) begin
      // The carry of the preceding add becomes the new MSB.
      product_d = {carry_q, product_q[2*WIDTH-1:1]};
      carry_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mcand_q   <= '0;
      product_q <= '0;
      carry_q   <= 1'b0;
    end else begin
      mcand_q   <= mcand_d;
      product_q <= product_d;
      carry_q   <= carry_d;
    end
  end

  assign product_o = product_q;

endmodule

// File: rtl/mul_shift_add_ctrl.sv
// Purpose: unsigned shift-add multiplier, two cycles per bit (add, then shift).
// Latency: ready rises 2*WIDTH edges after the start edge.
// Backpressure: run is ignored while busy; the result is held in DONE until the next run.
// Ports: clk, rst (async active-low), run, multiplicand, multiplier,
//        busy, ready, product (2*WIDTH, valid while ready=1).
module mul_shift_add_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = MUL_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               busy,
  output logic               ready,
  output logic [2*WIDTH-1:0] product
);

  localparam int unsigned CW = cnt_width(WIDTH);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic          busy_q,  busy_d;
  logic          ready_q, ready_d;
  logic          load, add_en, shift_en;
  logic          last_iter;

  // Compared before the increment, so the final SHIFT is the WIDTH-th one.
  assign last_iter = (count_q == CW'(WIDTH - 1));

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    busy_d   = busy_q;
    ready_d  = ready_q;
    load     = 1'b0;
    add_en   = 1'b0;
    shift_en = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        // A restart from DONE drops ready on the same edge that loads operands.
        if (run) begin
          load    = 1'b1;
          count_d = '0;
          busy_d  = 1'b1;
          ready_d = 1'b0;
          state_d = S_ADD;
        end
      end
      S_ADD: begin
        add_en  = 1'b1;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        shift_en = 1'b1;
        count_d  = count_q + 1'b1;
        if (last_iter) begin
          busy_d  = 1'b0;
          ready_d = 1'b1;
          state_d = S_DONE;
        end else begin
          state_d = S_ADD;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      count_q <= '0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
    end
  end

  mul_datapath #(
    .WIDTH(WIDTH)
  ) u_datapath (
    .clk       (clk),
    .rst       (rst),
    .load_i    (load),
    .add_en_i  (add_en),
    .shift_en_i(shift_en),
    .mcand_i   (multiplicand),
    .mplier_i  (multiplier),
    .product_o (product)
  );

  assign busy  = busy_q;
  assign ready = ready_q;

endmodule

// File: tb/tb_mul_shift_add_ctrl.sv
module tb_mul_shift_add_ctrl;

  localparam int W   = 32;
  localparam int LAT = 2 * W;

  logic           clk;
  logic           rst;
  logic           run;
  logic [W-1:0]   multiplicand;
  logic [W-1:0]   multiplier;
  logic           busy;
  logic           ready;
  logic [2*W-1:0] product;

  mul_shift_add_ctrl #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .run         (run),
    .multiplicand(multiplicand),
    .multiplier  (multiplier),
    .busy        (busy),
    .ready       (ready),
    .product     (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] p;
  } vec_t;

  vec_t           vecs[6];
  logic [2*W-1:0] sb[$];
  int             checks;
  int             failures;
  int             edges;

  task automatic chk(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Advance one edge; inputs are driven and outputs sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
    edges++;
  endtask

  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2*W-1:0] exp);
    run          = 1'b1;
    multiplicand = a;
    multiplier   = b;
    sb.push_back(exp);
    @(posedge clk);
    #1;
    run   = 1'b0;
    edges = 0;
    chk("busy_after_start", {63'd0, busy}, 64'd1);
    chk("ready_after_start", {63'd0, ready}, 64'd0);
  endtask

  task automatic finish_op(input string name);
    logic [2*W-1:0] exp;
    while (!ready && edges < LAT + 20) tick();
    chk({name, "_latency"}, 64'(edges), 64'(LAT));
    chk({name, "_ready"}, {63'd0, ready}, 64'd1);
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s_scoreboard actual=empty required=entry", name);
    end else begin
      exp = sb.pop_front();
      chk({name, "_product"}, product, exp);
    end
    chk({name, "_busy_done"}, {63'd0, busy}, 64'd0);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic [2*W-1:0] hold_p;

    checks   = 0;
    failures = 0;
    edges    = 0;

    vecs[0] = '{a: 32'd3,          b: 32'd5,          p: 64'd15};
    vecs[1] = '{a: 32'hFFFF_FFFF,  b: 32'hFFFF_FFFF,  p: 64'hFFFF_FFFE_0000_0001};
    vecs[2] = '{a: 32'd0,          b: 32'hDEAD_BEEF,  p: 64'd0};
    vecs[3] = '{a: 32'h1234_5678,  b: 32'd1,          p: 64'h0000_0000_1234_5678};
    vecs[4] = '{a: 32'd1,          b: 32'hFFFF_FFFF,  p: 64'h0000_0000_FFFF_FFFF};
    vecs[5] = '{a: 32'h8000_0000,  b: 32'h8000_0000,  p: 64'h4000_0000_0000_0000};

    rst          = 1'b0;
    run          = 1'b0;
    multiplicand = '0;
    multiplier   = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_ready", {63'd0, ready}, 64'd0);
    chk("reset_product", product, 64'd0);
    rst = 1'b1;
    tick();
    chk("idle_hold_ready", {63'd0, ready}, 64'd0);

    // Table-driven operations.
    for (int i = 0; i < 6; i++) begin
      start_op(vecs[i].a, vecs[i].b, vecs[i].p);
      finish_op($sformatf("vec%0d", i));
    end

    // A few random operands against the bench's own multiply model.
    for (int i = 0; i < 3; i++) begin
      ra = $urandom;
      rb = $urandom;
      start_op(ra, rb, 64'(ra) * 64'(rb));
      finish_op($sformatf("rand%0d", i));
    end

    // run and operand changes while busy are ignored.
    start_op(32'd7, 32'd9, 64'd63);
    repeat (19) tick();
    run          = 1'b1;
    multiplicand = 32'hFFFF_FFFF;
    multiplier   = 32'hFFFF_FFFF;
    tick();
    run = 1'b0;
    chk("busy_ignore_run", {63'd0, busy}, 64'd1);
    finish_op("ignore_run");

    // run coinciding with the final SHIFT edge has no effect.
    start_op(32'd11, 32'd13, 64'd143);
    repeat (LAT - 1) tick();
    run = 1'b1;
    tick();
    run = 1'b0;
    finish_op("run_on_last_shift");
    tick();
    chk("last_shift_still_ready", {63'd0, ready}, 64'd1);
    chk("last_shift_no_restart", {63'd0, busy}, 64'd0);
    chk("last_shift_product", product, 64'd143);

    // Asynchronous reset mid-operation.
    start_op(32'd100, 32'd200, 64'd20000);
    repeat (30) tick();
    #2;
    rst = 1'b0;
    #1;
    chk("midreset_busy", {63'd0, busy}, 64'd0);
    chk("midreset_ready", {63'd0, ready}, 64'd0);
    chk("midreset_product", product, 64'd0);
    sb.delete();
    tick();
    rst = 1'b1;
    tick();
    start_op(32'd2, 32'd3, 64'd6);
    finish_op("after_reset");

    // Back-to-back restart from DONE.
    start_op(32'd3, 32'd5, 64'd15);
    finish_op("b2b_first");
    hold_p = 64'd15;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("done_hold_ready%0d", i), {63'd0, ready}, 64'd1);
      chk($sformatf("done_hold_product%0d", i), product, hold_p);
    end
    start_op(32'h8000_0000, 32'd2, 64'h0000_0001_0000_0000);
    finish_op("b2b_second");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
